// File: rtl/aes_key_sched_ctrl_if.sv
// Handshake and data bundle between the key-load side, the round-key step unit
// and the cipher round controller. The key-schedule sequencer connects as slave.
interface aes_key_sched_ctrl_if #(
  parameter int unsigned KW = 128
);
  logic          start;
  logic          abort;
  logic [KW-1:0] cipher_key;
  logic [KW-1:0] step_key_in;
  logic [6:0]    step_round;
  logic          step_ldkey;
  logic [KW-1:0] step_key_out;
  logic [3:0]    rk_rd_addr;
  logic [KW-1:0] rk_rd_data;
  logic          busy;
  logic          done;
  logic          keys_valid;

  modport slave (
    input  start, abort, cipher_key, step_key_out, rk_rd_addr,
    output step_key_in, step_round, step_ldkey, rk_rd_data, busy, done, keys_valid
  );

  modport master (
    output start, abort, cipher_key, step_key_out, rk_rd_addr,
    input  step_key_in, step_round, step_ldkey, rk_rd_data, busy, done, keys_valid
  );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer. Feeds the external combinational step unit
// with the previous round key and round number, captures each generated round
// key into an 11-entry store, and serves registered reads of that store.
module aes_key_sched_ctrl #(
  parameter int unsigned NR = 10,
  parameter int unsigned KW = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  aes_key_sched_ctrl_if.slave   bus
);

  localparam logic [3:0] LastRound = 4'(NR);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StExpand = 2'd1,
    StDone   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    round_q, round_d;
  logic [KW-1:0] cur_key_q, cur_key_d;
  logic [KW-1:0] store_q [0:NR];
  logic [KW-1:0] store_d [0:NR];
  logic [KW-1:0] rd_data_q, rd_data_d;
  logic          done_q, done_d;
  logic          keys_valid_q, keys_valid_d;

  logic expanding;
  assign expanding = (state_q == StExpand);

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      round_q      <= '0;
      cur_key_q    <= '0;
      rd_data_q    <= '0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      for (int unsigned i = 0; i <= NR; i++) begin
        store_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      cur_key_q    <= cur_key_d;
      rd_data_q    <= rd_data_d;
      done_q       <= done_d;
      keys_valid_q <= keys_valid_d;
      for (int unsigned i = 0; i <= NR; i++) begin
        store_q[i] <= store_d[i];
      end
    end
  end

  // Next-state: load on start, step through rounds 1..NR, abort overrides all.
  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    cur_key_d    = cur_key_q;
    store_d      = store_q;
    done_d       = 1'b0;
    keys_valid_d = keys_valid_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          store_d[0]   = bus.cipher_key;
          cur_key_d    = bus.cipher_key;
          round_d      = 4'd1;
          keys_valid_d = 1'b0;
          state_d      = StExpand;
        end
      end
      StExpand: begin
        // start is ignored here so a running schedule is never disturbed.
        store_d[round_q] = bus.step_key_out;
        cur_key_d        = bus.step_key_out;
        if (round_q == LastRound) begin
          state_d      = StDone;
          done_d       = 1'b1;
          keys_valid_d = 1'b1;
          round_d      = '0;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        round_d = '0;
      end
    endcase

    // Abort leaves store contents untouched but marks them invalid.
    if (bus.abort) begin
      state_d      = StIdle;
      round_d      = '0;
      cur_key_d    = cur_key_q;
      store_d      = store_q;
      done_d       = 1'b0;
      keys_valid_d = 1'b0;
    end
  end

  // Read port: old store contents (no write bypass), zero beyond the last entry.
  always_comb begin
    rd_data_d = '0;
    if (bus.rk_rd_addr <= LastRound) begin
      rd_data_d = store_q[bus.rk_rd_addr];
    end
  end

  // Step-unit drive and status outputs, all straight from registers.
  always_comb begin
    bus.step_key_in = cur_key_q;
    bus.step_round  = expanding ? {3'b000, round_q} : 7'd0;
    bus.step_ldkey  = expanding;
    bus.busy        = expanding;
    bus.done        = done_q;
    bus.keys_valid  = keys_valid_q;
    bus.rk_rd_data  = rd_data_q;
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for the AES-128 key-schedule sequencer. A behavioural AES
// key-expansion step unit closes the loop; expected round keys are the
// published FIPS-197 values plus the well-known all-zero-key last round key.
module tb_aes_key_sched_ctrl;

  localparam logic [127:0] FipsKey = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] ZeroR10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

  logic clk;
  logic rst_n;

  aes_key_sched_ctrl_if #(.KW(128)) bus ();

  aes_key_sched_ctrl #(.NR(10), .KW(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural step unit.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] inv;
    inv = 8'h01;
    for (int k = 0; k < 254; k++) inv = gmul(inv, v);
    if (v == 8'h00) inv = 8'h00;
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [6:0] r);
    case (r)
      7'd1:    return 8'h01;
      7'd2:    return 8'h02;
      7'd3:    return 8'h04;
      7'd4:    return 8'h08;
      7'd5:    return 8'h10;
      7'd6:    return 8'h20;
      7'd7:    return 8'h40;
      7'd8:    return 8'h80;
      7'd9:    return 8'h1b;
      7'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [6:0] r);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    t  = t ^ {rcon(r), 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign bus.step_key_out = key_step(bus.step_key_in, bus.step_round);

  logic [127:0] fips_rk [0:10];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_run(input logic [127:0] key);
    bus.cipher_key = key;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  task automatic read_rk(input string tag, input logic [3:0] addr, input logic [127:0] exp);
    bus.rk_rd_addr = addr;
    tick();
    check(tag, bus.rk_rd_data, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic seen_done;
    fips_rk[0]  = FipsKey;
    fips_rk[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    fips_rk[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
    fips_rk[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
    fips_rk[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
    fips_rk[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
    fips_rk[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
    fips_rk[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
    fips_rk[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
    fips_rk[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
    fips_rk[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.cipher_key = '0;
    bus.rk_rd_addr = '0;

    // Reset state
    #2;
    check("rst_busy",  128'(bus.busy),       128'd0);
    check("rst_done",  128'(bus.done),       128'd0);
    check("rst_valid", 128'(bus.keys_valid), 128'd0);
    check("rst_ldkey", 128'(bus.step_ldkey), 128'd0);
    check("rst_round", 128'(bus.step_round), 128'd0);
    check("rst_rd",    bus.rk_rd_data,       128'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // FIPS-197 expansion: busy for rounds 1..10, done the cycle after E10
    start_run(FipsKey);
    check("fips_key_in", bus.step_key_in, FipsKey);
    for (int i = 1; i <= 10; i++) begin
      check("fips_busy",  128'(bus.busy),       128'd1);
      check("fips_round", 128'(bus.step_round), 128'(i));
      check("fips_nodone", 128'(bus.done),      128'd0);
      tick();
    end
    check("fips_done",     128'(bus.done),       128'd1);
    check("fips_busy_end", 128'(bus.busy),       128'd0);
    check("fips_valid",    128'(bus.keys_valid), 128'd1);
    check("fips_ldkey",    128'(bus.step_ldkey), 128'd0);
    tick();
    check("fips_done_1cy", 128'(bus.done),       128'd0);
    check("fips_valid_hold", 128'(bus.keys_valid), 128'd1);

    // Read-back sweep, addresses past 10 return zero
    for (int a = 0; a < 16; a++) begin
      read_rk($sformatf("rd_%0d", a), 4'(a), (a <= 10) ? fips_rk[a] : 128'd0);
    end

    // Start with a zero key mid-run must be ignored
    start_run(FipsKey);
    for (int c = 1; c <= 10; c++) begin
      check("sb_round", 128'(bus.step_round), 128'(c));
      check("sb_nodone", 128'(bus.done), 128'd0);
      bus.start = (c == 4);
      if (c == 4) bus.cipher_key = '0;
      tick();
    end
    bus.start = 1'b0;
    check("sb_done", 128'(bus.done), 128'd1);
    tick();
    check("sb_done_1cy", 128'(bus.done), 128'd0);
    read_rk("sb_rk0",  4'd0,  FipsKey);
    read_rk("sb_rk10", 4'd10, fips_rk[10]);

    // Back-to-back: zero key started in the done cycle of a FIPS run
    start_run(FipsKey);
    for (int c = 1; c <= 10; c++) tick();
    check("b2b_done1", 128'(bus.done), 128'd1);
    start_run(128'd0);
    check("b2b_valid_drop", 128'(bus.keys_valid), 128'd0);
    check("b2b_busy",       128'(bus.busy),       128'd1);
    check("b2b_round",      128'(bus.step_round), 128'd1);
    for (int c = 1; c <= 10; c++) tick();
    check("b2b_done2",  128'(bus.done),       128'd1);
    check("b2b_valid2", 128'(bus.keys_valid), 128'd1);
    read_rk("b2b_rk10", 4'd10, ZeroR10);
    read_rk("b2b_rk0",  4'd0,  128'd0);

    // Abort at round 6 with start on the same edge
    start_run(FipsKey);
    for (int c = 1; c <= 5; c++) tick();
    check("ab_round6", 128'(bus.step_round), 128'd6);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("ab_busy",  128'(bus.busy),       128'd0);
    check("ab_valid", 128'(bus.keys_valid), 128'd0);
    check("ab_round", 128'(bus.step_round), 128'd0);
    seen_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      seen_done = seen_done | bus.done | bus.busy;
      tick();
    end
    check("ab_no_done", 128'(seen_done), 128'd0);
    read_rk("ab_rk5", 4'd5, fips_rk[5]);
    read_rk("ab_rk0", 4'd0, FipsKey);

    // Asynchronous reset during round 3
    bus.rk_rd_addr = 4'd1;
    start_run(FipsKey);
    tick();
    tick();
    check("ar_round3", 128'(bus.step_round), 128'd3);
    check("ar_rd_pre", bus.rk_rd_data, fips_rk[1]);
    #1 rst_n = 1'b0;
    #1;
    check("ar_busy",   128'(bus.busy),       128'd0);
    check("ar_done",   128'(bus.done),       128'd0);
    check("ar_valid",  128'(bus.keys_valid), 128'd0);
    check("ar_ldkey",  128'(bus.step_ldkey), 128'd0);
    check("ar_round",  128'(bus.step_round), 128'd0);
    check("ar_rd",     bus.rk_rd_data,       128'd0);
    check("ar_key_in", bus.step_key_in,      128'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("ar_idle_busy",  128'(bus.busy),       128'd0);
    check("ar_idle_round", 128'(bus.step_round), 128'd0);
    check("ar_idle_valid", 128'(bus.keys_valid), 128'd0);
    read_rk("ar_rk1_clr", 4'd1, 128'd0);
    read_rk("ar_rk0_clr", 4'd0, 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Sequencer for the combinational AES-128 round-key step unit (RotWord, SubWord, Rcon add, word XOR chain). It drives that unit's previous-key and round inputs, then registers each generated round key into an 11-entry key store.
- The cipher round controller reads round keys from the store. It reads forward for encryption and in reverse for decryption.
- The block is placed between the key-load interface and the cipher round datapath.

Parameters:
- NR, 10, number of expansion rounds (AES-128). This block does not support any other value.
- KW, 128, key and round-key width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request expansion of cipher_key. Sampled on rising edge.
- abort  input  1  synchronous cancel of an expansion in progress.
- cipher_key  input  KW  initial key. word0 is in [127:96] and word3 is in [31:0].
- step_key_in  output  KW  previous round key, to the step unit.
- step_round  output  7  current round number 1..10, to the step unit.
- step_ldkey  output  1  high while a step result is being captured.
- step_key_out  input  KW  next round key, returned combinationally from the step unit.
- rk_rd_addr  input  4  round-key read index 0..10.
- rk_rd_data  output  KW  registered read data.
- busy  output  1  expansion in progress.
- done  output  1  one-cycle pulse when expansion completes.
- keys_valid  output  1  key store holds a complete, consistent schedule.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE and round counter goes to 0.
  - All 11 store entries, cur_key and rk_rd_data go to 0.
  - busy, done, keys_valid and step_ldkey go to 0. step_round is 0.
- States: IDLE, EXPAND, DONE.
- IDLE/DONE, start=1, abort=0, at edge E0:
  - store[0] <= cipher_key; cur_key <= cipher_key.
  - round <= 1; keys_valid <= 0; next state EXPAND.
- EXPAND:
  - step_key_in = cur_key, step_round = round, step_ldkey = 1. These are combinational from registers.
  - At each edge E1..E10: store[round] <= step_key_out; cur_key <= step_key_out; round <= round+1.
  - At E10 (round==NR): next state DONE, done <= 1, keys_valid <= 1, round <= 0.
- Outputs outside EXPAND: step_ldkey = 0, step_round = 0, step_key_in = cur_key.
- busy = 1 exactly while the state is EXPAND (the 10 cycles after E0).
- done is high for exactly one cycle, the cycle after E10.
- Latency: start to done is 11 cycles. A back-to-back start is accepted in the done cycle.
- DONE state: holds the schedule. It returns to EXPAND on start. It never returns to IDLE except via reset or abort.
- start while busy: ignored. The running expansion is not disturbed and cipher_key is not resampled.
- abort (any state):
  - next state IDLE, round <= 0, keys_valid <= 0, no done pulse.
  - Store contents are left as-is but flagged invalid.
  - If start and abort are high on the same edge, abort wins.
- Read port:
  - rk_rd_data <= store[rk_rd_addr] on every edge, giving one-cycle latency.
  - An address greater than 10 returns 0.
  - A read of an entry during the same edge it is written returns the old value; there is no bypass.
  - Reads are allowed while busy, but the data is only guaranteed consistent when keys_valid=1.
- Reset asserted mid-EXPAND: immediate return to reset values; no done pulse.
- Rcon selection (01,02,04,08,10,20,40,80,1B,36) belongs to the step unit and is keyed by step_round. This block only guarantees that step_round runs 1..10 in order with no skips or repeats.

Test Plan:
- FIPS-197 key. Stimulus: cipher_key=2b7e1516_28aed2a6_abf71588_09cf4f3c, start pulse. Required response:
  - busy for 10 cycles, then done is a single pulse 11 cycles after start.
  - store[1]=a0fafe17_88542cb1_23a33939_2a6c7605.
  - store[10]=d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
  - keys_valid=1.
- Read-back. Stimulus: after the FIPS run, sweep rk_rd_addr 0..15. Required response:
  - Each entry appears one cycle after its address; addr 0 returns cipher_key.
  - Addresses 11..15 return 0.
- Start during busy. Stimulus: at cycle 4 of EXPAND, pulse start with cipher_key=all-zero. Required response:
  - The run is unaffected and store[10] still equals d014f9a8...
  - done is a single pulse at the original cycle.
- Abort mid-run. Stimulus: abort at round 6, with start high on the same edge. Required response:
  - The FSM is IDLE next cycle, busy=0, keys_valid=0, and no done pulse occurs.
- Back-to-back runs. Stimulus: start the all-zero key in the done cycle of the FIPS run. Required response:
  - keys_valid drops next cycle.
  - After 10 more cycles, store[10]=b4ef5bcb_3e92e211_23e951cf_6f8f188e and done pulses again.
- Async reset. Stimulus: drive rst_n low for half a clock during round 3. Required response:
  - All outputs and rk_rd_data are 0 immediately.
  - After release, the FSM is IDLE and ignores a start with abort high.
